seg_scan_display: RTL and testbench

Parametrised multiplexed 7-segment scanner for the board display path. Drives DIGITS hex digits with one shared segment bus and a one-hot digit select. Adds a tear-free load handshake, per-digit decimal points, leading-zero blanking, enable/blank control, output polarity options and a frame strobe. Sits between the UART/debug data source and the board's segment and anode pins.

---
 rtl/seg_scan_display.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed hex 7-segment scanner: one shared segment bus, one-hot digit select,
// tear-free load (commit at frame wrap), leading-zero blanking and polarity options.
module seg_scan_display #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SCAN_CYCLES    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_en,
    input  logic                  I_load,
    input  logic [4*DIGITS-1:0]   I_data,
    input  logic [DIGITS-1:0]     I_dp,
    input  logic                  I_lz,
    output logic [7:0]            O_led,
    output logic [DIGITS-1:0]     O_px,
    output logic                  O_frame,
    output logic                  O_pending
);

    localparam int unsigned CW = $clog2(SCAN_CYCLES);
    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [CW-1:0]     CNT_MAX = CW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_POL = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;
    localparam logic [DIGITS-1:0] PX_RST  = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                run_q, run_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d, pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                disp_lz_q, disp_lz_d, pend_lz_q, pend_lz_d;
    logic                pend_q, pend_d;
    logic [7:0]          led_d;
    logic [DIGITS-1:0]   px_d;
    logic                wrap, commit, bypass, nz;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          seg;
    int unsigned         k;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        run_d  = I_en;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        wrap   = 1'b0;
        commit = 1'b0;
        bypass = 1'b0;
        // run_q low marks the first enabled edge: it re-selects digit 0 so the
        // dwell starts from that edge, and it acts as a commit point like a wrap.
        if (!I_en) begin
            cnt_d  = '0;
            idx_d  = '0;
            commit = 1'b1;
        end else if (!run_q) begin
            cnt_d  = '0;
            idx_d  = '0;
            commit = 1'b1;
            bypass = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d  = '0;
                wrap   = 1'b1;
                commit = 1'b1;
                bypass = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        disp_lz_d   = disp_lz_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_d      = pend_q;
        if (commit && pend_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            disp_lz_d   = pend_lz_q;
            pend_d      = 1'b0;
        end
        if (I_load) begin
            if (bypass) begin
                disp_data_d = I_data;
                disp_dp_d   = I_dp;
                disp_lz_d   = I_lz;
                pend_d      = 1'b0;
            end else begin
                pend_data_d = I_data;
                pend_dp_d   = I_dp;
                pend_lz_d   = I_lz;
                pend_d      = 1'b1;
            end
        end

        nz    = 1'b0;
        blank = '0;
        k     = 0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            k        = DIGITS - 1 - j;
            nz       = nz | (disp_data_d[4*k +: 4] != 4'h0);
            blank[k] = !nz && (k != 0);
        end

        seg = glyph(disp_data_d[{idx_d, 2'b00} +: 4]);
        if (disp_lz_d && blank[idx_d])
            seg = '0;

        led_d = '0;
        px_d  = '0;
        if (I_en) begin
            led_d = {disp_dp_d[idx_d], seg};
            for (int unsigned j = 0; j < DIGITS; j++)
                px_d[j] = (idx_d == IW'(j));
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            run_q       <= 1'b1;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            disp_lz_q   <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_lz_q   <= 1'b0;
            pend_q      <= 1'b0;
            O_led       <= 8'h7E ^ SEG_POL;
            O_px        <= PX_RST ^ SEL_POL;
            O_frame     <= 1'b0;
            O_pending   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            disp_lz_q   <= disp_lz_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_lz_q   <= pend_lz_d;
            pend_q      <= pend_d;
            O_led       <= led_d ^ SEG_POL;
            O_px        <= px_d ^ SEL_POL;
            O_frame     <= wrap;
            O_pending   <= pend_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, SCAN_CYCLES=4): a true-polarity
// instance and an inverted-polarity instance share all inputs.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [7:0]  led1, led2;
    logic [3:0]  px1, px2;
    logic        frame1, frame2, pend1, pend2;

    int n_checks = 0;
    int n_pass   = 0;
    int E        = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(4), .SCAN_CYCLES(4), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_load(load), .I_data(data), .I_dp(dp), .I_lz(lz),
        .O_led(led1), .O_px(px1), .O_frame(frame1), .O_pending(pend1));

    seg_scan_display #(.DIGITS(4), .SCAN_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut_inv (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_load(load), .I_data(data), .I_dp(dp), .I_lz(lz),
        .O_led(led2), .O_px(px2), .O_frame(frame2), .O_pending(pend2));

    task automatic tick();
        @(posedge clk);
        #1;
        E++;
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 64 && (E % 16) != target; i++) tick();
    endtask

    task automatic test_reset_scan();
        logic [3:0] exp_px;
        rst_n = 1'b0; en = 1'b1; load = 1'b0; data = '0; dp = '0; lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (px1 !== 4'b0001) $display("FAIL reset_px got %b exp 0001", px1); else n_pass++;
        n_checks++; if (led1 !== 8'h7E) $display("FAIL reset_led got %h exp 7e", led1); else n_pass++;
        n_checks++; if (frame1 !== 1'b0 || pend1 !== 1'b0) $display("FAIL reset_flags got %b%b exp 00", frame1, pend1); else n_pass++;
        n_checks++; if (led2 !== 8'h81) $display("FAIL reset_led_inv got %h exp 81", led2); else n_pass++;
        n_checks++; if (px2 !== 4'b1110) $display("FAIL reset_px_inv got %b exp 1110", px2); else n_pass++;
        rst_n = 1'b1;
        E = 0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            exp_px = 4'b0001 << ((E / 4) % 4);
            n_checks++; if (px1 !== exp_px) $display("FAIL scan_px E=%0d got %b exp %b", E, px1, exp_px); else n_pass++;
            n_checks++; if (led1 !== 8'h7E) $display("FAIL scan_led E=%0d got %h exp 7e", E, led1); else n_pass++;
            n_checks++; if (frame1 !== ((E % 16) == 0)) $display("FAIL scan_frame E=%0d got %b exp %b", E, frame1, (E % 16) == 0); else n_pass++;
            n_checks++; if (px2 !== ~exp_px || led2 !== 8'h81) $display("FAIL scan_inv E=%0d got %b/%h exp %b/81", E, px2, led2, ~exp_px); else n_pass++;
        end
    endtask

    task automatic test_load_commit();
        logic [7:0] exp_led [4];
        exp_led[0] = 8'h79; exp_led[1] = 8'h4E; exp_led[2] = 8'h5B; exp_led[3] = 8'h77;
        wait_phase(6);
        data = 16'hA5C3; dp = 4'b0000; lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++; if (pend1 !== 1'b1) $display("FAIL load_pending got %b exp 1", pend1); else n_pass++;
        n_checks++; if (led1 !== 8'h7E) $display("FAIL load_no_tear got %h exp 7e", led1); else n_pass++;
        for (int i = 0; i < 16 && (E % 16) != 0; i++) begin
            tick();
            if ((E % 16) != 0) begin
                n_checks++; if (pend1 !== 1'b1) $display("FAIL load_pending_hold E=%0d got %b exp 1", E, pend1); else n_pass++;
            end
        end
        n_checks++; if (pend1 !== 1'b0 || frame1 !== 1'b1) $display("FAIL commit_flags got p%b f%b exp p0 f1", pend1, frame1); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            wait_phase(4 * d);
            n_checks++; if (led1 !== exp_led[d]) $display("FAIL commit_led d%0d got %h exp %h", d, led1, exp_led[d]); else n_pass++;
            n_checks++; if (px1 !== (4'b0001 << d)) $display("FAIL commit_px d%0d got %b exp %b", d, px1, 4'b0001 << d); else n_pass++;
        end
    endtask

    task automatic test_lz_dp();
        logic [7:0] exp_led [4];
        exp_led[0] = 8'h6D; exp_led[1] = 8'h30; exp_led[2] = 8'h80; exp_led[3] = 8'h00;
        wait_phase(13);
        data = 16'h0012; dp = 4'b0100; lz = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        wait_phase(0);
        for (int d = 0; d < 4; d++) begin
            wait_phase(4 * d);
            n_checks++; if (led1 !== exp_led[d]) $display("FAIL lz_led d%0d got %h exp %h", d, led1, exp_led[d]); else n_pass++;
            n_checks++; if (px1 !== (4'b0001 << d)) $display("FAIL lz_px d%0d got %b exp %b", d, px1, 4'b0001 << d); else n_pass++;
        end
    endtask

    task automatic test_wrap_load();
        logic [7:0] exp_led [4];
        exp_led[0] = 8'hB3; exp_led[1] = 8'h79; exp_led[2] = 8'h6D; exp_led[3] = 8'h30;
        wait_phase(15);
        data = 16'h1234; dp = 4'b0001; lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++; if (frame1 !== 1'b1) $display("FAIL wrap_frame got %b exp 1", frame1); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            wait_phase(4 * d);
            n_checks++; if (led1 !== exp_led[d]) $display("FAIL wrap_led d%0d got %h exp %h", d, led1, exp_led[d]); else n_pass++;
            n_checks++; if (pend1 !== 1'b0) $display("FAIL wrap_pending d%0d got %b exp 0", d, pend1); else n_pass++;
        end
    endtask

    task automatic test_back_to_back_enable();
        wait_phase(2);
        data = 16'h1111; dp = '0; lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        wait_phase(5);
        data = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++; if (pend1 !== 1'b1) $display("FAIL b2b_pending got %b exp 1", pend1); else n_pass++;
        wait_phase(0);
        n_checks++; if (pend1 !== 1'b0) $display("FAIL b2b_commit got %b exp 0", pend1); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            wait_phase(4 * d);
            n_checks++; if (led1 !== 8'h6D) $display("FAIL b2b_led d%0d got %h exp 6d", d, led1); else n_pass++;
        end
        wait_phase(14);
        en = 1'b0;
        tick();
        n_checks++; if (px1 !== 4'b0000 || led1 !== 8'h00) $display("FAIL dis_dark got %b/%h exp 0000/00", px1, led1); else n_pass++;
        n_checks++; if (frame1 !== 1'b0) $display("FAIL dis_frame got %b exp 0", frame1); else n_pass++;
        n_checks++; if (px2 !== 4'b1111 || led2 !== 8'hFF) $display("FAIL dis_dark_inv got %b/%h exp 1111/ff", px2, led2); else n_pass++;
        data = 16'h00F0; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++; if (pend1 !== 1'b1) $display("FAIL dis_load_pending got %b exp 1", pend1); else n_pass++;
        tick();
        n_checks++; if (pend1 !== 1'b0) $display("FAIL dis_load_commit got %b exp 0", pend1); else n_pass++;
        n_checks++; if (px1 !== 4'b0000) $display("FAIL dis_hold_px got %b exp 0000", px1); else n_pass++;
        en = 1'b1;
        tick();
        E = 0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (px1 !== 4'b0001 || led1 !== 8'h7E) $display("FAIL reen_dwell c%0d got %b/%h exp 0001/7e", c, px1, led1); else n_pass++;
            tick();
        end
        n_checks++; if (px1 !== 4'b0010 || led1 !== 8'h47) $display("FAIL reen_next got %b/%h exp 0010/47", px1, led1); else n_pass++;
    endtask

    task automatic test_reset_mid_pending();
        data = 16'hFFFF; dp = 4'b1111; lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++; if (pend1 !== 1'b1 || pend2 !== 1'b1) $display("FAIL rstp_pending got %b%b exp 11", pend1, pend2); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (led2 !== 8'h81 || px2 !== 4'b1110) $display("FAIL rstp_async_inv got %h/%b exp 81/1110", led2, px2); else n_pass++;
        n_checks++; if (pend2 !== 1'b0 || frame2 !== 1'b0) $display("FAIL rstp_flags_inv got %b%b exp 00", pend2, frame2); else n_pass++;
        n_checks++; if (led1 !== 8'h7E || px1 !== 4'b0001 || pend1 !== 1'b0) $display("FAIL rstp_async got %h/%b/%b exp 7e/0001/0", led1, px1, pend1); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        E = 0;
        repeat (4) tick();
        n_checks++; if (px2 !== 4'b1101 || led2 !== 8'h81) $display("FAIL rstp_discard_inv got %b/%h exp 1101/81", px2, led2); else n_pass++;
        n_checks++; if (pend1 !== 1'b0 || led1 !== 8'h7E) $display("FAIL rstp_discard got %b/%h exp 0/7e", pend1, led1); else n_pass++;
    endtask

    initial begin
        test_reset_scan();
        test_load_commit();
        test_lz_dp();
        test_wrap_load();
        test_back_to_back_enable();
        test_reset_mid_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
